// File: rtl/fpu_vector_engine.sv
// rtl/fpu_vector_engine.sv - on-chip vector stimulus/checker for the fpu core
//
// Holds a DEPTH-entry store of {a, b, op, rmode, expected out, expected flags}.
// A run streams vectors 0..num_vec-1 into the fpu, one per clock. An
// FPU_LAT-deep token line tracks which vector each returning result belongs to.
// Each returning result and its flags are compared against the stored
// expectations. The block reports pass, a saturating mismatch count and the
// first failing index.
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   ld_we/ld_addr/ld_*                  vector store write port (IDLE only)
//   flag_mask                           1 = flag bit participates in compare
//   start, num_vec, stop_on_fail        run control
//   fpu_a/fpu_b/fpu_op/fpu_rmode        operands launched to the fpu
//   fpu_out, fpu_flags                  fpu result, FPU_LAT edges after launch
//   busy, done, pass, err_count,
//   fail_valid, first_fail_idx          run status
module fpu_vector_engine #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 64,
    parameter int OP_W    = 3,
    parameter int RM_W    = 2,
    parameter int FLAG_W  = 8,
    parameter int FPU_LAT = 4,
    parameter int CNT_W   = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_we,
    input  logic [AW-1:0]     ld_addr,
    input  logic [WIDTH-1:0]  ld_a,
    input  logic [WIDTH-1:0]  ld_b,
    input  logic [OP_W-1:0]   ld_op,
    input  logic [RM_W-1:0]   ld_rmode,
    input  logic [WIDTH-1:0]  ld_exp_out,
    input  logic [FLAG_W-1:0] ld_exp_flags,
    input  logic [FLAG_W-1:0] flag_mask,
    input  logic              start,
    input  logic [AW:0]       num_vec,
    input  logic              stop_on_fail,
    output logic [WIDTH-1:0]  fpu_a,
    output logic [WIDTH-1:0]  fpu_b,
    output logic [OP_W-1:0]   fpu_op,
    output logic [RM_W-1:0]   fpu_rmode,
    input  logic [WIDTH-1:0]  fpu_out,
    input  logic [FLAG_W-1:0] fpu_flags,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic              fail_valid,
    output logic [AW-1:0]     first_fail_idx
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    // Vector store: deliberately not reset so contents survive a mid-run reset.
    logic [WIDTH-1:0]  mem_a   [DEPTH];
    logic [WIDTH-1:0]  mem_b   [DEPTH];
    logic [OP_W-1:0]   mem_op  [DEPTH];
    logic [RM_W-1:0]   mem_rm  [DEPTH];
    logic [WIDTH-1:0]  mem_exp [DEPTH];
    logic [FLAG_W-1:0] mem_flg [DEPTH];

    state_t            state_q;
    logic [AW-1:0]     issue_idx_q;
    logic [AW-1:0]     last_idx_q;
    logic              stop_q;
    logic [FPU_LAT-1:0] dl_valid_q;
    logic [AW-1:0]     dl_tag_q [FPU_LAT];

    logic [WIDTH-1:0]  fpu_a_q, fpu_b_q;
    logic [OP_W-1:0]   fpu_op_q;
    logic [RM_W-1:0]   fpu_rmode_q;
    logic              busy_q, done_q, pass_q, fail_valid_q;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic [AW-1:0]     first_fail_q;

    logic [AW:0]       nv_clamped;
    logic              cmp_valid, mismatch, retire_last;
    logic [AW-1:0]     cmp_tag;

    always_ff @(posedge clk) begin
        if (ld_we && state_q == S_IDLE) begin
            mem_a[ld_addr]   <= ld_a;
            mem_b[ld_addr]   <= ld_b;
            mem_op[ld_addr]  <= ld_op;
            mem_rm[ld_addr]  <= ld_rmode;
            mem_exp[ld_addr] <= ld_exp_out;
            mem_flg[ld_addr] <= ld_exp_flags;
        end
    end

    assign nv_clamped = (num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_vec;

    // The oldest token line stage is the vector whose result is on fpu_out now.
    assign cmp_tag   = dl_tag_q[FPU_LAT-1];
    assign cmp_valid = (state_q == S_ISSUE || state_q == S_DRAIN) && dl_valid_q[FPU_LAT-1];
    assign mismatch  = cmp_valid &&
                       ((fpu_out != mem_exp[cmp_tag]) ||
                        (((fpu_flags ^ mem_flg[cmp_tag]) & flag_mask) != '0));
    assign retire_last = cmp_valid && (state_q == S_DRAIN) && (cmp_tag == last_idx_q);
    assign err_count_d = (mismatch && err_count_q != '1) ? err_count_q + CNT_W'(1) : err_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            issue_idx_q  <= '0;
            last_idx_q   <= '0;
            stop_q       <= 1'b0;
            dl_valid_q   <= '0;
            for (int i = 0; i < FPU_LAT; i++) dl_tag_q[i] <= '0;
            fpu_a_q      <= '0;
            fpu_b_q      <= '0;
            fpu_op_q     <= '0;
            fpu_rmode_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_count_q  <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        err_count_q  <= '0;
                        fail_valid_q <= 1'b0;
                        first_fail_q <= '0;
                        if (nv_clamped == '0) begin
                            pass_q  <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            pass_q      <= 1'b0;
                            last_idx_q  <= AW'(nv_clamped - 1'b1);
                            stop_q      <= stop_on_fail;
                            issue_idx_q <= '0;
                            busy_q      <= 1'b1;
                            state_q     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE, S_DRAIN: begin
                    if (mismatch) begin
                        err_count_q <= err_count_d;
                        if (!fail_valid_q) begin
                            fail_valid_q <= 1'b1;
                            first_fail_q <= cmp_tag;
                        end
                    end
                    if (mismatch && stop_q) begin
                        // Abort: drop every token still in flight, no further issue.
                        dl_valid_q <= '0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        pass_q     <= 1'b0;
                        state_q    <= S_DONE;
                    end else begin
                        for (int i = FPU_LAT-1; i > 0; i--) begin
                            dl_valid_q[i] <= dl_valid_q[i-1];
                            dl_tag_q[i]   <= dl_tag_q[i-1];
                        end
                        dl_valid_q[0] <= (state_q == S_ISSUE);
                        dl_tag_q[0]   <= issue_idx_q;
                        if (state_q == S_ISSUE) begin
                            fpu_a_q     <= mem_a[issue_idx_q];
                            fpu_b_q     <= mem_b[issue_idx_q];
                            fpu_op_q    <= mem_op[issue_idx_q];
                            fpu_rmode_q <= mem_rm[issue_idx_q];
                            issue_idx_q <= issue_idx_q + 1'b1;
                            if (issue_idx_q == last_idx_q) state_q <= S_DRAIN;
                        end else if (retire_last) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_count_d == '0);
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    fpu_a_q     <= '0;
                    fpu_b_q     <= '0;
                    fpu_op_q    <= '0;
                    fpu_rmode_q <= '0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign fpu_a          = fpu_a_q;
    assign fpu_b          = fpu_b_q;
    assign fpu_op         = fpu_op_q;
    assign fpu_rmode      = fpu_rmode_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign fail_valid     = fail_valid_q;
    assign first_fail_idx = first_fail_q;

endmodule

// File: tb/tb_fpu_vector_engine.sv
// tb/tb_fpu_vector_engine.sv - self-checking bench for fpu_vector_engine
module tb_fpu_vector_engine;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_we = 1'b0;
    logic [5:0]  ld_addr = '0;
    logic [31:0] ld_a = '0, ld_b = '0, ld_exp_out = '0;
    logic [2:0]  ld_op = '0;
    logic [1:0]  ld_rmode = '0;
    logic [7:0]  ld_exp_flags = '0, flag_mask = 8'hFF;
    logic        start = 1'b0, stop_on_fail = 1'b0;
    logic [6:0]  num_vec = '0;
    logic [31:0] fpu_a, fpu_b, fpu_out;
    logic [2:0]  fpu_op;
    logic [1:0]  fpu_rmode;
    logic [7:0]  fpu_flags;
    logic        busy, done, pass, fail_valid;
    logic [15:0] err_count;
    logic [5:0]  first_fail_idx;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] m_a [64], m_b [64], m_exp [64];
    logic [2:0]  m_op [64];
    logic [1:0]  m_rm [64];
    logic [7:0]  m_fl [64];
    logic [31:0] samp [$];
    logic [39:0] pipe [LAT-1];

    always #5 clk = ~clk;

    fpu_vector_engine dut (
        .clk(clk), .rst_n(rst_n), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_a(ld_a), .ld_b(ld_b), .ld_op(ld_op), .ld_rmode(ld_rmode),
        .ld_exp_out(ld_exp_out), .ld_exp_flags(ld_exp_flags), .flag_mask(flag_mask),
        .start(start), .num_vec(num_vec), .stop_on_fail(stop_on_fail),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_rmode(fpu_rmode),
        .fpu_out(fpu_out), .fpu_flags(fpu_flags), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .fail_valid(fail_valid),
        .first_fail_idx(first_fail_idx)
    );

    // Stand-in fpu: op 0 is a truncating add of positive normals, other ops a hash.
    function automatic logic [39:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op, input logic [1:0] rm);
        logic [31:0] x, y, r;
        logic [24:0] s;
        int sh;
        if (op == 3'd0) begin
            if (a[30:23] >= b[30:23]) begin x = a; y = b; end
            else begin x = b; y = a; end
            sh = int'(x[30:23]) - int'(y[30:23]);
            s = {2'b01, x[22:0]} + ((sh > 24) ? 25'd0 : ({2'b01, y[22:0]} >> sh));
            r = {1'b0, x[30:23], s[22:0]};
            if (s[24]) r = {1'b0, x[30:23] + 8'd1, s[23:1]};
            return {(r == 32'd0) ? 8'h02 : 8'h00, r};
        end
        r = (a ^ (b >> rm)) + 32'(op);
        return {a[7:0] & b[15:8], r};
    endfunction

    // Result appears FPU_LAT edges after the operands were launched.
    always @(posedge clk) begin
        pipe[0] <= fpu_fn(fpu_a, fpu_b, fpu_op, fpu_rmode);
        for (int i = 1; i < LAT-1; i++) pipe[i] <= pipe[i-1];
    end
    assign {fpu_flags, fpu_out} = pipe[LAT-2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic load_vec(input int i, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] op, input logic [1:0] rm,
                            input logic [31:0] ex, input logic [7:0] fl);
        @(negedge clk);
        ld_we = 1'b1; ld_addr = 6'(i); ld_a = a; ld_b = b; ld_op = op;
        ld_rmode = rm; ld_exp_out = ex; ld_exp_flags = fl;
        m_a[i] = a; m_b[i] = b; m_op[i] = op; m_rm[i] = rm; m_exp[i] = ex; m_fl[i] = fl;
        @(posedge clk);
        #1 ld_we = 1'b0;
    endtask

    task automatic fill(input int n);
        logic [31:0] a, b;
        logic [2:0]  op;
        logic [1:0]  rm;
        logic [39:0] r;
        for (int i = 0; i < n; i++) begin
            a  = {8'(i), 24'($urandom)};
            b  = $urandom;
            op = 3'($urandom);
            rm = 2'($urandom);
            r  = fpu_fn(a, b, op, rm);
            load_vec(i, a, b, op, rm, r[31:0], r[39:32]);
        end
    endtask

    function automatic bit mism(input int i);
        logic [39:0] r;
        r = fpu_fn(m_a[i], m_b[i], m_op[i], m_rm[i]);
        return (r[31:0] != m_exp[i]) || (((r[39:32] ^ m_fl[i]) & flag_mask) != 8'h00);
    endfunction

    // Reference: which vectors fail, and how many edges from start to done.
    task automatic expect_run(input int n, input bit stop, output int err,
                              output int first, output int edges);
        int nn, cnt;
        nn = (n > 64) ? 64 : n;
        cnt = 0;
        first = -1;
        for (int i = 0; i < nn; i++) begin
            if (mism(i)) begin
                cnt++;
                if (first < 0) first = i;
                if (stop) break;
            end
        end
        err = (cnt > 65535) ? 65535 : cnt;
        if (nn == 0) edges = 1;
        else if (stop && first >= 0) edges = first + LAT + 2;
        else edges = nn + LAT + 1;
    endtask

    // Edge 1 is the edge that samples start; returns the edge count at done.
    task automatic run(input int n, input bit stop, input int inj, input int rst_at,
                       output int edges);
        samp.delete();
        @(negedge clk);
        num_vec = 7'(n); stop_on_fail = stop; start = 1'b1;
        @(posedge clk);
        edges = 1;
        #1 start = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            samp.push_back(fpu_a);
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_mid_busy", 64'(busy), 64'd0);
                chk("rst_mid_fpu_a", 64'(fpu_a), 64'd0);
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    chk("rst_mid_nodone", 64'(done), 64'd0);
                end
                rst_n = 1'b1;
                edges = -1;
                return;
            end
            if (done) return;
            if (k == inj) begin
                start = 1'b1; ld_we = 1'b1; ld_addr = 6'd2; ld_exp_out = ~m_exp[2];
            end
            @(posedge clk);
            edges++;
            #1 start = 1'b0; ld_we = 1'b0;
        end
        chk("done_timeout", 64'd0, 64'd1);
        edges = -1;
    endtask

    task automatic run_chk(input string tag, input int n, input bit stop, input int inj);
        int e, ee, er, ef;
        run(n, stop, inj, -1, e);
        expect_run(n, stop, er, ef, ee);
        chk({tag, "_lat"}, 64'(e), 64'(ee));
        chk({tag, "_err"}, 64'(err_count), 64'(er));
        chk({tag, "_pass"}, 64'(pass), 64'(er == 0));
        chk({tag, "_fv"}, 64'(fail_valid), 64'(ef >= 0));
        if (ef >= 0) chk({tag, "_idx"}, 64'(first_fail_idx), 64'(ef));
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int e, mx;
        repeat (3) @(negedge clk);
        chk("rst_status", {58'd0, busy, done, pass, fail_valid, 2'b00}, 64'd0);
        chk("rst_err", 64'(err_count), 64'd0);
        chk("rst_fpu", {fpu_a, fpu_b}, 64'd0);
        rst_n = 1'b1;

        // Single known vector: 1.0 + 2.0 = 3.0
        flag_mask = 8'hFF;
        load_vec(0, 32'h3F800000, 32'h40000000, 3'd0, 2'd0, 32'h40400000, 8'h00);
        run_chk("one", 1, 1'b0, -1);
        chk("one_pass_c", 64'(pass), 64'd1);

        // Full store, two corrupted expectations
        fill(64);
        m_exp[5] = m_exp[5] ^ 32'h1;
        load_vec(5, m_a[5], m_b[5], m_op[5], m_rm[5], m_exp[5], m_fl[5]);
        m_exp[40] = m_exp[40] ^ 32'h80000000;
        load_vec(40, m_a[40], m_b[40], m_op[40], m_rm[40], m_exp[40], m_fl[40]);
        run_chk("full", 64, 1'b0, -1);
        chk("full_err_c", 64'(err_count), 64'd2);
        for (int k = 0; k < 64; k++) chk($sformatf("seq%0d", k), 64'(samp[k+1]), 64'(m_a[k]));

        // Same store, abort at first mismatch
        run_chk("stop", 64, 1'b1, -1);
        chk("stop_err_c", 64'(err_count), 64'd1);
        mx = 0;
        foreach (samp[k]) if (int'(samp[k][31:24]) > mx) mx = int'(samp[k][31:24]);
        chk("stop_maxidx", 64'(mx <= 5 + LAT), 64'd1);

        // ine-only flag difference, checked then masked
        fill(1);
        m_fl[0] = m_fl[0] ^ 8'h10;
        load_vec(0, m_a[0], m_b[0], m_op[0], m_rm[0], m_exp[0], m_fl[0]);
        flag_mask = 8'hFF;
        run_chk("ine_on", 1, 1'b0, -1);
        flag_mask = 8'hEF;
        run_chk("ine_off", 1, 1'b0, -1);
        chk("ine_off_pass_c", 64'(pass), 64'd1);
        flag_mask = 8'hFF;

        run_chk("zero", 0, 1'b0, -1);

        // start and ld_we while busy are ignored; rerun proves store intact
        fill(8);
        run_chk("busy_inj", 8, 1'b0, 3);
        run_chk("reread", 8, 1'b0, -1);

        // num_vec above DEPTH clamps
        fill(64);
        run_chk("clamp", 100, 1'b0, -1);

        // Reset mid-run, then clean short run
        run(20, 1'b0, -1, 10, e);
        chk("post_rst_err", 64'(err_count), 64'd0);
        run_chk("after_rst", 3, 1'b0, -1);
        chk("after_rst_pass_c", 64'(pass), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fpu_vector_engine.md
Name: fpu_vector_engine

Overview:
Synthesizable on-chip stimulus/checker for the fpu core. It holds a parametrised vector store of operands, opcodes, rounding modes and expected results. It streams one vector per clock into the fpu, tracks in-flight vectors over a configurable pipeline latency, and compares each fpu result and flag set against the expected values. It reports pass/fail, a saturating error count and the first failing index, for silicon/FPGA self-test and for regression runs that need no file I/O.

Parameters:
WIDTH, 32, operand/result width
DEPTH, 64, vector store entries (power of 2)
OP_W, 3, fpu opcode width
RM_W, 2, rounding-mode width
FLAG_W, 8, flag vector width {inf,snan,qnan,ine,overflow,underflow,zero,div_by_zero}
FPU_LAT, 4, clock edges from operand launch to result valid (>=1)
CNT_W, 16, error counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ld_we  in  1  vector store write strobe
ld_addr  in  log2(DEPTH)  write address
ld_a  in  WIDTH  operand a
ld_b  in  WIDTH  operand b
ld_op  in  OP_W  opcode
ld_rmode  in  RM_W  rounding mode
ld_exp_out  in  WIDTH  expected result
ld_exp_flags  in  FLAG_W  expected flags
flag_mask  in  FLAG_W  1 = flag bit checked
start  in  1  run pulse
num_vec  in  log2(DEPTH)+1  vectors to run, from index 0
stop_on_fail  in  1  abort run at first mismatch
fpu_a  out  WIDTH  to fpu
fpu_b  out  WIDTH  to fpu
fpu_op  out  OP_W  to fpu
fpu_rmode  out  RM_W  to fpu
fpu_out  in  WIDTH  from fpu
fpu_flags  in  FLAG_W  from fpu
busy  out  1  run in progress
done  out  1  one-cycle pulse at run end
pass  out  1  last run had zero mismatches
err_count  out  CNT_W  mismatches in last run, saturating
fail_valid  out  1  first_fail_idx is meaningful
first_fail_idx  out  log2(DEPTH)  index of first mismatch

Behaviour:
- Reset: all outputs 0. FSM in IDLE. Delay line cleared. Vector store contents are not reset.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: ld_we writes all six fields at ld_addr on the clock edge. On start with num_vec=0: go to DONE, pass=1, err_count=0. On start with num_vec>0: latch num_vec, clear err_count/fail_valid/pass, issue_idx=0, go to ISSUE.
- ISSUE: every edge registers mem[issue_idx] onto fpu_a/b/op/rmode. A valid token tagged with issue_idx is pushed into an FPU_LAT-deep delay line. issue_idx increments. After the edge issuing index num_vec-1, go to DRAIN.
- Compare: a token pushed on edge E is compared on edge E+FPU_LAT. Mismatch = (fpu_out != exp_out) OR ((fpu_flags ^ exp_flags) & flag_mask) != 0.
- On a mismatch: err_count increments, holding at all-ones. On the first mismatch, first_fail_idx=tag and fail_valid=1.
- DRAIN: no new issue; fpu_* outputs hold the last vector. Go to DONE on the edge that retires the last token.
- stop_on_fail=1 (latched at start): the first mismatch goes to DONE on that edge. Remaining tokens are discarded and err_count=1.
- DONE: done=1 for exactly one cycle, pass=(err_count==0), busy=0, return to IDLE. pass/err_count/first_fail hold until the next start.
- busy=1 in ISSUE and DRAIN.
- start while busy: ignored. ld_we while busy: ignored (store protected).
- num_vec > DEPTH: clamped to DEPTH.
- fpu_* outputs are driven to 0 in IDLE.
- rst_n low mid-run: immediate return to reset state. No done pulse.
- Throughput: N vectors complete in N+FPU_LAT+1 cycles from start to done.

Test Plan:
- Load idx0 a=0x3F800000, b=0x40000000, op=0, exp=0x40400000, flags=0, mask=0xFF; num_vec=1, start -> done after FPU_LAT+2 cycles; pass=1, err_count=0, fail_valid=0.
- Load 64 vectors with correct expectations, exp at idx 5 and idx 40 corrupted, stop_on_fail=0 -> err_count=2, first_fail_idx=5, pass=0; fpu_a changes on each of 64 consecutive edges.
- Same load, stop_on_fail=1 -> done on the edge comparing idx 5; err_count=1; no vector beyond idx 5+FPU_LAT issued.
- Flag mismatch on ine only: mask=0xFF -> err_count=1; mask with ine bit cleared -> pass=1.
- num_vec=0 -> done next cycle, pass=1. start asserted during busy, and ld_we during busy -> both ignored; the store re-read after the run matches the original.
- Assert rst_n=0 at the 10th issue cycle -> busy=0, fpu_a=0, no done pulse. A new start with num_vec=3 then runs cleanly to pass=1.
